// File: rtl/muntjac_irq_ctrl.sv
// muntjac_irq_ctrl: interrupt arbiter and trap-request sequencer.
// Each cycle it selects the highest-priority pending, enabled and
// privilege-eligible interrupt, and offers it to the trap logic as a held
// request. After an accept it waits out a settle window so the CSR file can
// apply the trap side effects. It also produces the WFI wake-up.
//
// Handshake: intr_valid_o/intr_cause_o/intr_priv_o are registered and stay
// stable while valid is high. A transfer happens on a cycle where
// intr_valid_o && intr_ready_i. Ready seen while valid is low is ignored.
// A request can be retracted before acceptance, but only when its interrupt
// is no longer eligible or block_i is high. Ready wins over retraction.
module muntjac_irq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] mip_i,
  input  logic [11:0] mie_i,
  input  logic [11:0] mideleg_i,
  input  logic [1:0]  priv_lvl_i,
  input  logic        mstatus_mie_i,
  input  logic        mstatus_sie_i,
  input  logic        block_i,
  output logic        intr_valid_o,
  output logic [4:0]  intr_cause_o,
  output logic [1:0]  intr_priv_o,
  input  logic        intr_ready_i,
  output logic        wake_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0]  PRIV_LVL_U = 2'b00;
  localparam logic [1:0]  PRIV_LVL_S = 2'b01;
  localparam logic [1:0]  PRIV_LVL_M = 2'b11;
  localparam logic [11:0] IRQ_MASK   = 12'hAAA;
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } state_e;

  state_e     state;
  logic [3:0] settle_cnt;

  logic [11:0] pend;
  logic        m_global;
  logic        s_global;
  logic [11:0] m_set;
  logic [11:0] s_set;
  logic        cand_any;
  logic [3:0]  cand_idx;
  logic [1:0]  cand_priv;
  logic [3:0]  held_idx;
  logic        held_ok;

  // Fixed priority within one class: MEI > MSI > MTI > SEI > SSI > STI.
  function automatic logic [3:0] prio_idx(input logic [11:0] s);
    if (s[11])     return 4'd11;
    else if (s[3]) return 4'd3;
    else if (s[7]) return 4'd7;
    else if (s[9]) return 4'd9;
    else if (s[1]) return 4'd1;
    else           return 4'd5;
  endfunction

  assign pend     = mip_i & mie_i & IRQ_MASK;
  assign m_global = (priv_lvl_i != PRIV_LVL_M) || mstatus_mie_i;
  assign s_global = (priv_lvl_i == PRIV_LVL_U) ||
                    ((priv_lvl_i == PRIV_LVL_S) && mstatus_sie_i);
  assign m_set    = pend & ~mideleg_i & {12{m_global}};
  assign s_set    = pend &  mideleg_i & {12{s_global}};

  // Candidate selection: any M-class interrupt beats every S-class one.
  always_comb begin
    cand_any  = 1'b0;
    cand_idx  = 4'd0;
    cand_priv = PRIV_LVL_M;
    if (|m_set) begin
      cand_any  = 1'b1;
      cand_idx  = prio_idx(m_set);
      cand_priv = PRIV_LVL_M;
    end else if (|s_set) begin
      cand_any  = 1'b1;
      cand_idx  = prio_idx(s_set);
      cand_priv = PRIV_LVL_S;
    end
  end

  // The held request stays alive only while its own bit is still eligible
  // in the class it was latched for.
  assign held_idx = intr_cause_o[3:0];
  assign held_ok  = (intr_priv_o == PRIV_LVL_M) ? m_set[held_idx] : s_set[held_idx];

  // Request sequencer: IDLE -> PENDING -> SETTLE -> IDLE, outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      intr_valid_o <= 1'b0;
      intr_cause_o <= 5'b0;
      intr_priv_o  <= PRIV_LVL_M;
      settle_cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cand_any && !block_i) begin
            state        <= ST_PENDING;
            intr_valid_o <= 1'b1;
            intr_cause_o <= {1'b1, cand_idx};
            intr_priv_o  <= cand_priv;
          end
        end
        ST_PENDING: begin
          if (intr_ready_i) begin
            state        <= ST_SETTLE;
            intr_valid_o <= 1'b0;
            settle_cnt   <= SETTLE_LOAD;
          end else if (!held_ok || block_i) begin
            state        <= ST_IDLE;
            intr_valid_o <= 1'b0;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state        <= ST_IDLE;
          intr_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // WFI wake: registered "anything pending and enabled", nothing else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wake_o <= 1'b0;
    end else begin
      wake_o <= |pend;
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_muntjac_irq_ctrl.sv
// Directed bench for muntjac_irq_ctrl. Two instances: the default settle
// window (2) for the functional scenarios and a 4-cycle window for the
// reset-during-settle scenario. Inputs change 1ns after a rising edge;
// outputs are sampled at that same point, i.e. they reflect the last edge.
module tb_muntjac_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] mip;
  logic [11:0] mie;
  logic [11:0] mideleg;
  logic [1:0]  priv_lvl;
  logic        mstatus_mie;
  logic        mstatus_sie;
  logic        block;
  logic        ready;
  logic        ready4;

  logic        valid,  valid4;
  logic [4:0]  cause,  cause4;
  logic [1:0]  priv,   priv4;
  logic        wake,   wake4;
  logic [1:0]  state,  state4;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  muntjac_irq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .mip_i(mip), .mie_i(mie), .mideleg_i(mideleg),
    .priv_lvl_i(priv_lvl), .mstatus_mie_i(mstatus_mie), .mstatus_sie_i(mstatus_sie),
    .block_i(block), .intr_valid_o(valid), .intr_cause_o(cause), .intr_priv_o(priv),
    .intr_ready_i(ready), .wake_o(wake), .dbg_state_o(state)
  );

  muntjac_irq_ctrl #(.SETTLE_CYCLES(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .mip_i(mip), .mie_i(mie), .mideleg_i(mideleg),
    .priv_lvl_i(priv_lvl), .mstatus_mie_i(mstatus_mie), .mstatus_sie_i(mstatus_sie),
    .block_i(block), .intr_valid_o(valid4), .intr_cause_o(cause4), .intr_priv_o(priv4),
    .intr_ready_i(ready4), .wake_o(wake4), .dbg_state_o(state4)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Accept the current request while dropping all pending bits, then let
  // the settle window drain so the next scenario starts from IDLE.
  task automatic drain();
    ready = 1'b1;
    mip   = 12'h000;
    tick();
    ready = 1'b0;
    ticks(4);
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; mip = '0; mie = '0; mideleg = '0; priv_lvl = 2'b00;
    mstatus_mie = 1'b0; mstatus_sie = 1'b0; block = 1'b0; ready = 1'b0; ready4 = 1'b0;
    ticks(2);
    check("rst_valid", valid, 0);
    check("rst_cause", cause, 0);
    check("rst_priv",  priv,  2'b11);
    check("rst_wake",  wake,  0);
    check("rst_state", state, 0);
    rst = 1'b0;
    tick();

    // Single M timer from U-mode
    mie = 12'h080; mip = 12'h080;
    tick();
    check("mti_valid", valid, 1);
    check("mti_cause", cause, 5'b10111);
    check("mti_priv",  priv,  2'b11);
    check("mti_wake",  wake,  1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("mti_settle1", valid, 0);
    tick();
    check("mti_settle2", valid, 0);
    tick();
    check("mti_idle", valid, 0);
    tick();
    check("mti_again_valid", valid, 1);
    check("mti_again_cause", cause, 5'b10111);
    drain();

    // Priority and delegation from S-mode
    priv_lvl = 2'b01; mstatus_sie = 1'b1;
    mie = 12'h222; mideleg = 12'h222; mip = 12'h222;
    tick();
    check("sei_valid", valid, 1);
    check("sei_cause", cause, 5'b11001);
    check("sei_priv",  priv,  2'b01);
    mideleg = 12'h220;
    tick();
    check("sei_held_valid", valid, 1);
    check("sei_held_cause", cause, 5'b11001);
    check("sei_held_priv",  priv,  2'b01);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("sei_acc", valid, 0);
    ticks(3);
    check("ssi_m_valid", valid, 1);
    check("ssi_m_cause", cause, 5'b10001);
    check("ssi_m_priv",  priv,  2'b11);
    drain();
    mideleg = 12'h000; mstatus_sie = 1'b0;

    // Masking in M-mode
    priv_lvl = 2'b11; mstatus_mie = 1'b0;
    mie = 12'h800; mip = 12'h800;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mmask_valid", valid, 0);
    end
    check("mmask_wake", wake, 1);
    mstatus_mie = 1'b1;
    tick();
    check("mei_valid", valid, 1);
    check("mei_cause", cause, 5'b11011);
    check("mei_priv",  priv,  2'b11);

    // Retraction: pending drops, then block, then ready wins over drop
    mip = 12'h000;
    tick();
    check("retract_mip_valid", valid, 0);
    check("retract_mip_wake",  wake,  0);
    mip = 12'h800;
    tick();
    check("reraise_valid", valid, 1);
    block = 1'b1;
    tick();
    block = 1'b0;
    check("retract_blk_valid", valid, 0);
    tick();
    check("reraise2_valid", valid, 1);
    mip = 12'h000; ready = 1'b1;
    tick();
    ready = 1'b0; mip = 12'h800;
    check("acc_drop_a1", valid, 0);
    tick();
    check("acc_drop_a2", valid, 0);
    tick();
    check("acc_drop_a3", valid, 0);
    tick();
    check("acc_drop_a4", valid, 1);
    drain();
    mstatus_mie = 1'b0;

    // Stability: held MTI not preempted by a later MEI
    priv_lvl = 2'b00;
    mie = 12'h880; mip = 12'h080;
    tick();
    check("stab_cause0", cause, 5'b10111);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) mip = 12'h880;
      tick();
      check("stab_valid", valid, 1);
      check("stab_cause", cause, 5'b10111);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("stab_acc", valid, 0);
    ticks(3);
    check("stab_mei_valid", valid, 1);
    check("stab_mei_cause", cause, 5'b11011);
    drain();

    // Reset during PENDING and mid-SETTLE on the 4-cycle instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mie = 12'h080; mip = 12'h080;
    tick();
    check("r4_pend_valid", valid4, 1);
    rst = 1'b1;
    tick();
    check("r4_rst_valid", valid4, 0);
    check("r4_rst_cause", cause4, 0);
    check("r4_rst_priv",  priv4,  2'b11);
    check("r4_rst_wake",  wake4,  0);
    check("r4_rst_state", state4, 0);
    rst = 1'b0;
    tick();
    check("r4_reraise_valid", valid4, 1);
    ready4 = 1'b1;
    tick();
    ready4 = 1'b0;
    check("r4_settle_state", state4, 2);
    tick();
    check("r4_settle_valid", valid4, 0);
    rst = 1'b1;
    tick();
    check("r4_rst2_valid", valid4, 0);
    check("r4_rst2_state", state4, 0);
    check("r4_rst2_wake",  wake4,  0);
    rst = 1'b0;
    tick();
    check("r4_after_valid", valid4, 1);
    check("r4_after_cause", cause4, 5'b10111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
